vx_dcache_tcm_responder: RTL

- Memory-side responder for the core's per-thread dcache request/response interface. Serves a pipeline's dcache port directly as a tightly-coupled word memory.
- Accepts multi-lane load/store requests, performs byte-enabled writes, and returns load data after a fixed pipeline latency.
- Buffers responses in an in-order queue with credit-based backpressure.
- Used for cache-less core configurations and as a deterministic memory model in core-level benches.

---
 rtl/vx_dcache_tcm_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vx_dcache_tcm_responder.sv
// Tightly-coupled word memory answering a multi-lane dcache port with fixed-latency, in-order load responses.
// Optional VX_TCM_PERF_EN adds perf_reads/perf_writes/perf_stalls counter outputs.
module vx_dcache_tcm_responder #(
  parameter int NUM_REQS    = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 dcache_req_valid,
  input  logic [NUM_REQS-1:0]                 dcache_req_rw,
  input  logic [NUM_REQS-1:0][3:0]            dcache_req_byteen,
  input  logic [NUM_REQS-1:0][29:0]           dcache_req_addr,
  input  logic [NUM_REQS-1:0][31:0]           dcache_req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  dcache_req_tag,
  output logic [NUM_REQS-1:0]                 dcache_req_ready,
  output logic                                dcache_rsp_valid,
  output logic [NUM_REQS-1:0]                 dcache_rsp_tmask,
  output logic [NUM_REQS-1:0][31:0]           dcache_rsp_data,
  output logic [TAG_WIDTH-1:0]                dcache_rsp_tag,
  input  logic                                dcache_rsp_ready
`ifdef VX_TCM_PERF_EN
  ,
  output logic [31:0]                         perf_reads,
  output logic [31:0]                         perf_writes,
  output logic [31:0]                         perf_stalls
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [CW-1:0]                      outstanding;
  logic                               ready;
  logic                               accept;
  logic                               rd_accept;
  logic                               pop;
  logic [NUM_REQS-1:0]                rmask;
  logic [NUM_REQS-1:0]                wmask;
  logic [NUM_REQS-1:0][31:0]          rd_data;
  logic [TAG_WIDTH-1:0]               rd_tag;

  logic                               push_valid;
  logic [NUM_REQS-1:0]                push_mask;
  logic [NUM_REQS-1:0][31:0]          push_data;
  logic [TAG_WIDTH-1:0]               push_tag;

  logic [NUM_REQS-1:0]                q_mask [QUEUE_DEPTH];
  logic [NUM_REQS-1:0][31:0]          q_data [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]               q_tag  [QUEUE_DEPTH];
  logic [PW:0]                        wr_ptr;
  logic [PW:0]                        rd_ptr;
  logic                               q_empty;

  logic                               unused_addr_hi;

  // Ready is held low while in reset so nothing is accepted or written then.
  assign ready            = reset && (outstanding < CW'(QUEUE_DEPTH));
  assign dcache_req_ready = {NUM_REQS{ready}};
  assign accept           = ready && (|dcache_req_valid);
  assign rmask            = dcache_req_valid & ~dcache_req_rw;
  assign wmask            = dcache_req_valid & dcache_req_rw;
  assign rd_accept        = accept && (|rmask);
  assign pop              = dcache_rsp_valid && dcache_rsp_ready;

  always_comb begin
    unused_addr_hi = 1'b0;
    for (int i = 0; i < NUM_REQS; i++)
      unused_addr_hi = unused_addr_hi ^ (^dcache_req_addr[i][29:ADDR_WIDTH]);
  end

  // Descending scan leaves the lowest-index read lane's tag as the response tag.
  always_comb begin
    rd_data = '0;
    rd_tag  = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (rmask[i]) begin
        rd_data[i] = mem[dcache_req_addr[i][ADDR_WIDTH-1:0]];
        rd_tag     = dcache_req_tag[i];
      end
    end
  end

  // Ascending lane order makes the highest lane win per byte on same-word conflicts.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[i] && dcache_req_byteen[i][b])
            mem[dcache_req_addr[i][ADDR_WIDTH-1:0]][b*8 +: 8] <= dcache_req_data[i][b*8 +: 8];
        end
      end
    end
  end

  // The queue write is the last of the LATENCY register stages.
  if (LATENCY == 1) begin : g_no_pipe
    assign push_valid = rd_accept;
    assign push_mask  = rmask;
    assign push_data  = rd_data;
    assign push_tag   = rd_tag;
  end else begin : g_pipe
    logic                      pv [LATENCY-1];
    logic [NUM_REQS-1:0]       pm [LATENCY-1];
    logic [NUM_REQS-1:0][31:0] pd [LATENCY-1];
    logic [TAG_WIDTH-1:0]      pt [LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < LATENCY - 1; i++) pv[i] <= 1'b0;
      end else begin
        pv[0] <= rd_accept;
        for (int i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pm[0] <= rmask;
      pd[0] <= rd_data;
      pt[0] <= rd_tag;
      for (int i = 1; i < LATENCY - 1; i++) begin
        pm[i] <= pm[i-1];
        pd[i] <= pd[i-1];
        pt[i] <= pt[i-1];
      end
    end

    assign push_valid = pv[LATENCY-2];
    assign push_mask  = pm[LATENCY-2];
    assign push_data  = pd[LATENCY-2];
    assign push_tag   = pt[LATENCY-2];
  end

  always_ff @(posedge clk) begin
    if (push_valid) begin
      q_mask[wr_ptr[PW-1:0]] <= push_mask;
      q_data[wr_ptr[PW-1:0]] <= push_data;
      q_tag[wr_ptr[PW-1:0]]  <= push_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The outstanding limit bounds the queue, so pushes never need a full check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign q_empty          = (wr_ptr == rd_ptr);
  assign dcache_rsp_valid = !q_empty;
  assign dcache_rsp_tmask = q_empty ? '0 : q_mask[rd_ptr[PW-1:0]];
  assign dcache_rsp_data  = q_empty ? '0 : q_data[rd_ptr[PW-1:0]];
  assign dcache_rsp_tag   = q_empty ? '0 : q_tag[rd_ptr[PW-1:0]];

`ifdef VX_TCM_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_accept)                          perf_reads  <= perf_reads + 32'd1;
      if (accept && (|wmask))                 perf_writes <= perf_writes + 32'd1;
      if ((|dcache_req_valid) && !ready)      perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
